// File: rtl/aes_dec_input_loader.sv
// rtl/aes_dec_input_loader.sv - byte-serial frame loader feeding the AES decryption core.
// Optional key reuse across frames is enabled by defining LOADER_KEY_REUSE_EN.
module aes_dec_input_loader #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CT_BYTES       = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic [1:0]   mode,
`ifdef LOADER_KEY_REUSE_EN
  input  logic         key_reuse,
`endif
  output logic [255:0] key_out,
  output logic [127:0] state_out,
  output logic [1:0]   mux_out,
  output logic         dec_reset,
  input  logic         dec_finish,
  output logic         busy,
  output logic         done,
  output logic         err_len,
  output logic         err_mode,
  output logic         err_timeout
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_CT,
    S_DRAIN,
    S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [31:0][7:0]    r_key;
  logic [15:0][7:0]    r_ct;
  logic [1:0]          r_mux;
  logic [4:0]          r_key_idx;
  logic [3:0]          r_ct_idx;
  logic [TW-1:0]       r_tmo;
  logic                r_in_ready;
  logic                r_dec_reset;
  logic                r_done;
  logic                r_err_len;
  logic                r_err_mode;
  logic                r_err_timeout;

  logic                w_xfer;
  logic                w_done;
  logic                w_err_len;
  logic                w_err_mode;
  logic                w_err_timeout;
  logic                w_reuse_ok;
  logic                w_reuse_bad;
  logic                w_mode_err;
  logic [4:0]          w_key_last;
  logic                w_ct_last;
  logic                w_tmo_hit;

`ifdef LOADER_KEY_REUSE_EN
  logic r_key_valid;
  assign w_reuse_ok  = key_reuse && r_key_valid && (mode == r_mux);
  assign w_reuse_bad = key_reuse && !w_reuse_ok;
`else
  assign w_reuse_ok  = 1'b0;
  assign w_reuse_bad = 1'b0;
`endif

  assign w_xfer     = in_valid && r_in_ready;
  assign w_mode_err = (mode == 2'b11) || w_reuse_bad;
  assign w_ct_last  = (r_ct_idx == 4'(CT_BYTES - 1));
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (r_mux)
      2'b00:   w_key_last = 5'd15;
      2'b01:   w_key_last = 5'd23;
      default: w_key_last = 5'd31;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_done        = 1'b0;
    w_err_len     = 1'b0;
    w_err_mode    = 1'b0;
    w_err_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_mode_err) begin
            w_err_mode   = 1'b1;
            w_next_state = in_last ? S_IDLE : S_DRAIN;
          end else if (in_last) begin
            w_err_len    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = w_reuse_ok ? S_LOAD_CT : S_LOAD_KEY;
          end
        end
      end
      S_LOAD_KEY: begin
        if (w_xfer) begin
          if (in_last) begin
            w_err_len    = 1'b1;
            w_next_state = S_IDLE;
          end else if (r_key_idx == w_key_last) begin
            w_next_state = S_LOAD_CT;
          end
        end
      end
      S_LOAD_CT: begin
        if (w_xfer) begin
          if (w_ct_last) begin
            if (in_last) begin
              w_next_state = S_RUN;
            end else begin
              w_err_len    = 1'b1;
              w_next_state = S_DRAIN;
            end
          end else if (in_last) begin
            w_err_len    = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (w_xfer && in_last) w_next_state = S_IDLE;
      end
      S_RUN: begin
        // finish takes priority over a coincident timeout
        if (dec_finish) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (w_tmo_hit) begin
          w_err_timeout = 1'b1;
          w_next_state  = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready    <= 1'b0;
      r_dec_reset   <= 1'b1;
      r_done        <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_mode    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_in_ready    <= (w_next_state != S_RUN);
      r_dec_reset   <= (w_next_state != S_RUN);
      r_done        <= w_done;
      r_err_len     <= w_err_len;
      r_err_mode    <= w_err_mode;
      r_err_timeout <= w_err_timeout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key     <= '0;
      r_ct      <= '0;
      r_mux     <= 2'b00;
      r_key_idx <= 5'd0;
      r_ct_idx  <= 4'd0;
      r_tmo     <= '0;
`ifdef LOADER_KEY_REUSE_EN
      r_key_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_ct     <= '0;
            r_ct_idx <= 4'd0;
            if (w_reuse_ok) begin
              r_ct[CT_BYTES-1] <= in_data;
              r_ct_idx         <= 4'd1;
            end else begin
              r_mux     <= mode;
              r_key     <= '0;
              r_key_idx <= 5'd1;
              if (!w_mode_err) r_key[31] <= in_data;
`ifdef LOADER_KEY_REUSE_EN
              r_key_valid <= 1'b0;
`endif
            end
          end
        end
        S_LOAD_KEY: begin
          if (w_xfer) begin
            r_key[5'd31 - r_key_idx] <= in_data;
            r_key_idx                <= r_key_idx + 5'd1;
`ifdef LOADER_KEY_REUSE_EN
            if (!in_last && (r_key_idx == w_key_last)) r_key_valid <= 1'b1;
`endif
          end
        end
        S_LOAD_CT: begin
          if (w_xfer) begin
            r_ct[4'd15 - r_ct_idx] <= in_data;
            r_ct_idx               <= r_ct_idx + 4'd1;
          end
        end
        default: ;
      endcase
      r_tmo <= (r_state == S_RUN) ? r_tmo + TW'(1) : '0;
    end
  end

  assign in_ready    = r_in_ready;
  assign key_out     = r_key;
  assign state_out   = r_ct;
  assign mux_out     = r_mux;
  assign dec_reset   = r_dec_reset;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err_len     = r_err_len;
  assign err_mode    = r_err_mode;
  assign err_timeout = r_err_timeout;

endmodule

// File: doc/aes_dec_input_loader.md
Name: aes_dec_input_loader

Overview:
Upstream feeder for the AES decryption core. It accepts one frame over a byte-serial valid/ready stream: key bytes followed by 16 ciphertext bytes. It assembles the frame into the core's 256-bit key, 128-bit state and 2-bit mode inputs, then releases the core's reset and waits for its finish flag. It handles frame-length errors and timeouts, and returns the core to reset between frames.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed in RUN before dec_finish must assert; legal range 1..1023.
CT_BYTES, 16, ciphertext bytes per frame; fixed, not to be overridden.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
in_valid  input  1  byte valid
in_ready  output  1  loader accepts byte
in_data  input  8  frame byte
in_last  input  1  marks final byte of frame
mode  input  2  key size (00=128, 01=192, 10=256, 11=illegal); sampled with first byte
key_out  output  256  key to core
state_out  output  128  ciphertext to core
mux_out  output  2  latched mode to core
dec_reset  output  1  core reset; high except in RUN
dec_finish  input  1  core finish flag
busy  output  1  high in any state other than IDLE
done  output  1  1-cycle pulse on successful completion
err_len  output  1  1-cycle pulse on frame-length error
err_mode  output  1  1-cycle pulse on mode 11
err_timeout  output  1  1-cycle pulse on RUN timeout

Behaviour:
- Reset values: key_out=0, state_out=0, mux_out=0, dec_reset=1, in_ready=0, busy=0, done=0, and all err_* outputs 0. FSM enters IDLE.
- A byte transfers when in_valid and in_ready are both high on a rising clk edge.
- States and transitions:
  - IDLE: in_ready=1. On the first transfer, latch mode into mux_out. Clear key_out and state_out in the same cycle.
    - mode=11: pulse err_mode and go to DRAIN; if in_last is high on this byte, return to IDLE instead.
    - Otherwise: store the byte as key byte 0 and go to LOAD_KEY.
  - LOAD_KEY: key length K=16/24/32 bytes for mode 00/01/10.
    - Byte n goes to key_out[255-8n -: 8], MSB-first.
    - Unused low bits stay 0; for 128-bit keys, key_out[127:0]=0.
    - After byte K-1 is accepted, go to LOAD_CT.
  - LOAD_CT: byte m goes to state_out[127-8m -: 8].
    - in_last on byte 15: go to RUN.
    - in_last on any earlier key or ciphertext byte: pulse err_len and return to IDLE. Outputs keep their partial contents; dec_reset stays 1.
    - Byte 15 without in_last: pulse err_len and go to DRAIN.
  - DRAIN: in_ready=1. Discard bytes until one arrives with in_last, then go to IDLE.
  - RUN: in_ready=0, dec_reset=0.
    - The 8-bit-min timeout counter clears on entry and increments each cycle.
    - dec_finish=1: pulse done, go to IDLE. dec_reset returns to 1 on the same edge.
    - Counter reaches TIMEOUT_CYCLES-1 without finish: pulse err_timeout, go to IDLE.
    - If dec_finish and the timeout coincide, finish wins: done pulses and err_timeout does not.
- Latency: dec_reset falls on the edge after the last ciphertext byte is accepted. done is registered and asserts the cycle after dec_finish is sampled high.
- dec_finish is ignored outside RUN. A dec_finish still high from the previous frame is masked because dec_reset is held in IDLE/LOAD.
- key_out, state_out and mux_out are stable throughout RUN.
- An asynchronous reset mid-frame or mid-RUN aborts immediately to reset values, and dec_reset=1.

Optional Feature:
Macro LOADER_KEY_REUSE_EN.
- When defined: adds input port key_reuse (1 bit), sampled with the first byte of a frame.
  - key_reuse=1 and mode matches the latched mux_out: key_out is retained, the first byte is ciphertext byte 0, and the FSM goes to LOAD_CT. state_out is cleared.
  - key_reuse=1 and mode mismatches: pulse err_mode and go to DRAIN.
  - key_reuse=1 with no key loaded since reset: pulse err_mode and go to DRAIN.
- When undefined: the port is absent and every frame carries a full key.

Test Plan:
- AES-128 FIPS-197 frame, mode=00: key 00..0f, then ct 69c4e0d86a7b0430d8cdb78070b4c55a with in_last on byte 31 → key_out=000102..0f followed by 128'h0, state_out=69c4..5a, mux_out=00. dec_reset falls 1 cycle later; dec_finish pulse → done for one cycle, dec_reset=1.
- AES-256 frame, mode=10: key 00..1f plus the same 16 ct bytes (48 bytes total) → key_out=000102..1f, RUN entered after byte 47.
- Early in_last on byte 20 of a mode=00 frame → err_len pulse, FSM back in IDLE, dec_reset stays 1. A following valid frame completes normally.
- mode=11 with a 10-byte frame → err_mode pulse, all 10 bytes accepted (in_ready=1), returns to IDLE after the last byte, key_out=0.
- Valid frame, dec_finish held low → err_timeout pulses exactly TIMEOUT_CYCLES cycles after RUN entry (64); dec_reset=1 afterwards.
- Assert reset on the 5th cycle of RUN → all outputs at reset values in the same cycle; the next frame loads correctly.
